// File: rtl/rv_seq_checker.sv
// rv_seq_checker: ready/valid sink that checks an incrementing payload sequence,
// generates its own backpressure and flags handshake violations and idle timeouts.
module rv_seq_checker #(
    parameter int          DATA_WIDTH   = 8,
    parameter int          READY_MODE   = 0,
    parameter int          STALL_PERIOD = 4,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1,
    parameter int          START_VALUE  = 0,
    parameter int          CNT_WIDTH    = 16,
    parameter int          TIMEOUT      = 1000
) (
    input  logic                  clock_port,
    input  logic                  reset_port,
    input  logic [DATA_WIDTH-1:0] input_port_data,
    input  logic                  input_port_valid,
    output logic                  input_port_ready,
    output logic [CNT_WIDTH-1:0]  beat_count,
    output logic [CNT_WIDTH-1:0]  error_count,
    output logic                  error_flag,
    output logic                  protocol_error,
    output logic                  timeout,
    output logic [DATA_WIDTH-1:0] first_err_expected,
    output logic [DATA_WIDTH-1:0] first_err_received
);
    localparam int PW = $clog2(STALL_PERIOD);
    localparam int IW = $clog2(TIMEOUT + 1);

    logic [15:0]           lfsr_q, lfsr_d;
    logic [PW-1:0]         phase_q, phase_d;
    logic                  ready_q, ready_d;
    logic [DATA_WIDTH-1:0] exp_q, exp_d;
    logic [CNT_WIDTH-1:0]  beat_q, beat_d, err_q, err_d;
    logic                  flag_q, flag_d, proto_q, proto_d, tout_q, tout_d;
    logic [DATA_WIDTH-1:0] fe_q, fe_d, fr_q, fr_d;
    logic                  pend_q, pend_d;
    logic [DATA_WIDTH-1:0] pdata_q, pdata_d;
    logic [IW-1:0]         idle_q, idle_d;
    logic                  accept, mismatch, violation;

    always_comb begin
        accept    = input_port_valid & ready_q;
        mismatch  = accept && (input_port_data != exp_q);
        violation = pend_q && (!input_port_valid || (input_port_data != pdata_q));
        lfsr_d    = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        phase_d   = (phase_q == PW'(STALL_PERIOD - 1)) ? '0 : phase_q + 1'b1;
        // ready is derived from the current-cycle state so it lags the generator by one cycle
        ready_d   = (READY_MODE == 1) ? lfsr_q[0] :
                    (READY_MODE == 2) ? (phase_q != PW'(STALL_PERIOD - 1)) : 1'b1;
        exp_d     = accept ? input_port_data + 1'b1 : exp_q;
        beat_d    = (accept && (beat_q != '1)) ? beat_q + 1'b1 : beat_q;
        err_d     = (mismatch && (err_q != '1)) ? err_q + 1'b1 : err_q;
        flag_d    = flag_q | mismatch;
        fe_d      = (mismatch && !flag_q) ? exp_q : fe_q;
        fr_d      = (mismatch && !flag_q) ? input_port_data : fr_q;
        pend_d    = input_port_valid & ~ready_q;
        pdata_d   = input_port_data;
        proto_d   = proto_q | violation;
        idle_d    = accept ? '0 : (idle_q == IW'(TIMEOUT)) ? idle_q : idle_q + 1'b1;
        tout_d    = tout_q | (idle_d == IW'(TIMEOUT));
    end

    always_ff @(posedge clock_port) begin
        if (!reset_port) begin
            lfsr_q  <= LFSR_SEED;
            phase_q <= '0;
            ready_q <= 1'b0;
            exp_q   <= DATA_WIDTH'(START_VALUE);
            beat_q  <= '0;
            err_q   <= '0;
            flag_q  <= 1'b0;
            fe_q    <= '0;
            fr_q    <= '0;
            pend_q  <= 1'b0;
            pdata_q <= '0;
            proto_q <= 1'b0;
            idle_q  <= '0;
            tout_q  <= 1'b0;
        end else begin
            lfsr_q  <= lfsr_d;
            phase_q <= phase_d;
            ready_q <= ready_d;
            exp_q   <= exp_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
            flag_q  <= flag_d;
            fe_q    <= fe_d;
            fr_q    <= fr_d;
            pend_q  <= pend_d;
            pdata_q <= pdata_d;
            proto_q <= proto_d;
            idle_q  <= idle_d;
            tout_q  <= tout_d;
        end
    end

    assign input_port_ready   = ready_q;
    assign beat_count         = beat_q;
    assign error_count        = err_q;
    assign error_flag         = flag_q;
    assign protocol_error     = proto_q;
    assign timeout            = tout_q;
    assign first_err_expected = fe_q;
    assign first_err_received = fr_q;
endmodule

// File: tb/tb_rv_seq_checker.sv
// tb_rv_seq_checker: directed stimulus for three checker configurations; expected
// values are queued by the stimulus and compared by an independent monitor.
module tb_rv_seq_checker;
    localparam int B0 = 0, E0 = 1, F0 = 2, P0 = 3, T0 = 4, X0 = 5, Y0 = 6, R0 = 7;
    localparam int B1 = 8, E1 = 9, P1 = 10, B2 = 11, E2 = 12, P2 = 13, R2 = 14, F2 = 15;

    typedef struct {
        int          sel;
        logic [31:0] exp;
        string       name;
    } item_t;

    logic clk, rst_n;
    logic [7:0] d0, d1, d2;
    logic v0, v1, v2, r0, r1, r2;
    logic [15:0] b0, e0, b1, e1, b2, e2;
    logic f0, f1, f2, p0, p1, p2, t0, t1, t2;
    logic [7:0] x0, y0, x1, y1, x2, y2;
    item_t sb[$];
    int checks = 0;
    int failures = 0;

    rv_seq_checker #(.READY_MODE(0), .TIMEOUT(10)) u0 (
        .clock_port(clk), .reset_port(rst_n), .input_port_data(d0), .input_port_valid(v0),
        .input_port_ready(r0), .beat_count(b0), .error_count(e0), .error_flag(f0),
        .protocol_error(p0), .timeout(t0), .first_err_expected(x0), .first_err_received(y0));

    rv_seq_checker #(.READY_MODE(1)) u1 (
        .clock_port(clk), .reset_port(rst_n), .input_port_data(d1), .input_port_valid(v1),
        .input_port_ready(r1), .beat_count(b1), .error_count(e1), .error_flag(f1),
        .protocol_error(p1), .timeout(t1), .first_err_expected(x1), .first_err_received(y1));

    rv_seq_checker #(.READY_MODE(2), .STALL_PERIOD(4)) u2 (
        .clock_port(clk), .reset_port(rst_n), .input_port_data(d2), .input_port_valid(v2),
        .input_port_ready(r2), .beat_count(b2), .error_count(e2), .error_flag(f2),
        .protocol_error(p2), .timeout(t2), .first_err_expected(x2), .first_err_received(y2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] get(input int sel);
        case (sel)
            B0: return 32'(b0);
            E0: return 32'(e0);
            F0: return 32'(f0);
            P0: return 32'(p0);
            T0: return 32'(t0);
            X0: return 32'(x0);
            Y0: return 32'(y0);
            R0: return 32'(r0);
            B1: return 32'(b1);
            E1: return 32'(e1);
            P1: return 32'(p1);
            B2: return 32'(b2);
            E2: return 32'(e2);
            P2: return 32'(p2);
            R2: return 32'(r2);
            F2: return 32'(f2);
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic push(input int sel, input logic [31:0] e, input string n);
        sb.push_back('{sel, e, n});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic send0(input logic [7:0] d);
        logic ok, rdy;
        ok = 1'b0;
        v0 = 1'b1;
        d0 = d;
        for (int n = 0; n < 8 && !ok; n++) begin
            rdy = r0;
            @(posedge clk); #1;
            ok = rdy;
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL send0_accept actual=not_accepted required=accepted data=%0d", d);
        end
    endtask

    initial begin : monitor
        item_t it;
        logic [31:0] act;
        forever begin
            @(negedge clk);
            while (sb.size() != 0) begin
                it = sb.pop_front();
                act = get(it.sel);
                checks++;
                if (act !== it.exp) begin
                    failures++;
                    $display("FAIL %s actual=%0d expected=%0d", it.name, act, it.exp);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench did not finish");
    end

    initial begin : stim
        rst_n = 1'b0;
        {v0, v1, v2} = '0;
        {d0, d1, d2} = '0;
        do_reset();
        push(R0, 0, "rst_ready"); push(B0, 0, "rst_beat"); push(E0, 0, "rst_err");
        push(F0, 0, "rst_flag"); push(P0, 0, "rst_proto"); push(T0, 0, "rst_timeout");
        push(X0, 0, "rst_fe"); push(Y0, 0, "rst_fr");
        for (int i = 0; i < 300; i++) send0(8'(i));
        push(B0, 300, "wrap_beat"); push(E0, 0, "wrap_err");
        push(F0, 0, "wrap_flag"); push(P0, 0, "wrap_proto");
        v0 = 1'b0;
        do_reset();
        send0(0); send0(1); send0(2); send0(7); send0(8); send0(9);
        push(E0, 1, "resync_err"); push(X0, 3, "resync_fe"); push(Y0, 7, "resync_fr");
        push(F0, 1, "resync_flag"); push(B0, 6, "resync_beat");
        v0 = 1'b0;
        do_reset();
        v0 = 1'b1; d0 = 8'd9;
        @(posedge clk); #1;
        d0 = 8'd7;
        @(posedge clk); #1;
        push(E0, 1, "both_err"); push(F0, 1, "both_flag"); push(P0, 1, "both_proto");
        push(X0, 0, "both_fe"); push(Y0, 7, "both_fr"); push(B0, 1, "both_beat");
        v0 = 1'b0;
        do_reset();
        repeat (9) @(posedge clk);
        #1 push(T0, 0, "timeout_edge9");
        @(posedge clk); #1;
        push(T0, 1, "timeout_edge10");
        repeat (3) @(posedge clk);
        #1 push(T0, 1, "timeout_sticky");
        v0 = 1'b1; d0 = 8'd3;
        do_reset();
        v0 = 1'b0;
        push(R0, 0, "rst2_ready"); push(B0, 0, "rst2_beat"); push(E0, 0, "rst2_err");
        push(F0, 0, "rst2_flag"); push(P0, 0, "rst2_proto"); push(T0, 0, "rst2_timeout");
        push(X0, 0, "rst2_fe"); push(Y0, 0, "rst2_fr");
        send0(0);
        push(E0, 0, "post_rst_err"); push(B0, 1, "post_rst_beat");
        push(P0, 0, "post_rst_proto"); push(F0, 0, "post_rst_flag");
        v0 = 1'b0;
        do_reset();
        v1 = 1'b1; d1 = 8'd1;
        @(posedge clk); #1;
        push(P1, 0, "lfsr_proto_before");
        d1 = 8'd0;
        @(posedge clk); #1;
        push(P1, 1, "lfsr_proto_after"); push(E1, 0, "lfsr_err"); push(B1, 1, "lfsr_beat");
        v1 = 1'b0;
        do_reset();
        v2 = 1'b1; d2 = 8'd0;
        for (int j = 0; j < 40; j++) begin
            logic rdy;
            push(R2, 32'((j % 4) != 0), $sformatf("stall_ready_c%0d", j));
            rdy = r2;
            @(posedge clk); #1;
            if (rdy) d2 = d2 + 8'd1;
        end
        push(B2, 30, "stall_beat"); push(E2, 0, "stall_err");
        push(P2, 0, "stall_proto"); push(F2, 0, "stall_flag");
        v2 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rv_seq_checker.md
RV_SEQ_CHECKER -- requirements
Module: rv_seq_checker

Interface
REQ-001 Parameter DATA_WIDTH, default 8: payload width in bits, range 1..32.
REQ-002 Parameter READY_MODE, default 0: backpressure mode; 0 = always ready, 1 = LFSR-throttled, 2 = periodic stall.
REQ-003 Parameter STALL_PERIOD, default 4: mode-2 period in cycles, range 2..256.
REQ-004 Parameter LFSR_SEED, default 16'hACE1: mode-1 LFSR reset value; must be non-zero.
REQ-005 Parameter START_VALUE, default 0: first expected payload value.
REQ-006 Parameter CNT_WIDTH, default 16: width of all counters.
REQ-007 Parameter TIMEOUT, default 1000: idle-cycle limit for the watchdog.
REQ-008 Ports SHALL be, clock and reset first; one clock; reset is synchronous and active-low:
- clock_port  in  1  sole clock, rising edge.
- reset_port  in  1  synchronous active-low reset.
- input_port_data  in  DATA_WIDTH  payload.
- input_port_valid  in  1  source valid.
- input_port_ready  out  1  sink ready (registered).
- beat_count  out  CNT_WIDTH  accepted beats.
- error_count  out  CNT_WIDTH  data mismatches.
- error_flag  out  1  sticky data-mismatch flag.
- protocol_error  out  1  sticky handshake-rule violation flag.
- timeout  out  1  sticky watchdog expiry flag.
- first_err_expected  out  DATA_WIDTH  expected value at first mismatch.
- first_err_received  out  DATA_WIDTH  received value at first mismatch.

Function
REQ-009 A beat is accepted in any cycle where input_port_valid=1 and input_port_ready=1.
REQ-010 Expected register: reset value START_VALUE; on each accepted beat it SHALL load (input_port_data+1) mod 2^DATA_WIDTH, resyncing after any mismatch.
REQ-011 Payload check: mismatch = accepted beat with input_port_data != expected; error_count increments, saturating at all-ones.
REQ-012 Mismatch capture: first mismatch sets error_flag and loads first_err_expected/first_err_received; later mismatches leave both captures unchanged.
REQ-013 beat_count increments per accepted beat; saturates at all-ones.
REQ-014 Mode 0: input_port_ready=1 every cycle after the first post-reset cycle.
REQ-015 Mode 1 LFSR: 16-bit Fibonacci, taps 16,14,13,11; advances every cycle; input_port_ready = registered LFSR bit 0.
REQ-016 Mode 2 counter: phase counter 0..STALL_PERIOD-1, wrapping; input_port_ready=0 only in phase STALL_PERIOD-1.
REQ-017 Protocol rule: if valid=1 and ready=0, the next cycle must have valid=1 with unchanged data; otherwise protocol_error is set (sticky); the check never blocks acceptance.
REQ-018 Watchdog: idle counter clears on each accepted beat, else increments; reaching TIMEOUT sets timeout (sticky); counter holds at TIMEOUT.
REQ-019 Data wrap: expected wraps from 2^DATA_WIDTH-1 to 0 without error.
REQ-020 Simultaneous mismatch and protocol violation in one cycle: both flags set; error_count +1.
REQ-021 No combinational path from any input to any output.

Reset
REQ-022 reset_port=0 sampled at a clock edge: input_port_ready=0; all counters, flags and captures=0; expected=START_VALUE; LFSR=LFSR_SEED; phase=0.
REQ-023 Reset asserted mid-operation SHALL abort any pending beat; the first cycle after deassertion behaves identically to the first cycle after power-up reset.

Verification
REQ-024 Mode 0, DATA_WIDTH=8, source sends 0..299 with valid held high -> beat_count=300, error_count=0, expected wraps 255->0, error_flag=0.
REQ-025 Mode 0, sequence 0,1,2,7,8,9 -> error_count=1, first_err_expected=3, first_err_received=7, no further errors (resync).
REQ-026 Mode 2, STALL_PERIOD=4, valid held high for 40 cycles -> ready low exactly every 4th cycle; 30 beats accepted, no error.
REQ-027 Mode 1, data changed while valid=1 and ready=0 -> protocol_error=1 the next cycle; error_count unchanged.
REQ-028 TIMEOUT=10, valid held low 10 cycles -> timeout=1 at cycle 10; reset_port=0 for one cycle -> all outputs 0, expected=START_VALUE.
